// File: rtl/gf180mcu_fd_sc_mcu9t5v0__incr_reg.sv
// Registered half-adder-chain incrementer with load, sticky wrap flag and a
// combinational carry-out for building synchronous multi-word counters.

module gf180mcu_fd_sc_mcu9t5v0__incr_reg_func #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             CO,
  output logic             OVF
);

  logic [WIDTH-1:0] r_q;
  logic             r_ovf;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_next;
  logic             w_co;
  logic             w_ovf_next;

  // Half-adder ripple: EN is the carry into bit 0, the last carry is CO.
  always_comb begin
    logic v_c;
    v_c   = EN;
    w_sum = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      w_sum[i] = r_q[i] ^ v_c;
      v_c      = r_q[i] & v_c;
    end
    w_co = v_c;
  end

  // Ternaries let an unknown LD/EN merge into X only on the bits that differ.
  always_comb begin
    w_next     = LD ? D : (EN ? w_sum : r_q);
    w_ovf_next = LD ? 1'b0 : (r_ovf | w_co);
  end

  // State flops; load wins over count, OVF stays set until load or reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_q   <= {WIDTH{1'b0}};
      r_ovf <= 1'b0;
    end else begin
      r_q   <= w_next;
      r_ovf <= w_ovf_next;
    end
  end

  assign Q   = r_q;
  assign OVF = r_ovf;
  assign CO  = w_co;

endmodule

module gf180mcu_fd_sc_mcu9t5v0__incr_reg #(
  parameter int WIDTH = 4
) (
`ifdef USE_POWER_PINS
  inout  wire              VDD,
  inout  wire              VSS,
`endif
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             CO,
  output logic             OVF
);

`ifdef USE_POWER_PINS
  gf180mcu_fd_sc_mcu9t5v0__incr_reg_func #(.WIDTH(WIDTH)) u_func (
    .CLK (CLK),
    .RST (RST),
    .EN  (EN),
    .LD  (LD),
    .D   (D),
    .Q   (Q),
    .CO  (CO),
    .OVF (OVF)
  );
`else
  gf180mcu_fd_sc_mcu9t5v0__incr_reg_func #(.WIDTH(WIDTH)) u_func (
    .CLK (CLK),
    .RST (RST),
    .EN  (EN),
    .LD  (LD),
    .D   (D),
    .Q   (Q),
    .CO  (CO),
    .OVF (OVF)
  );
`endif

`ifndef FUNCTIONAL
  // Q cannot be a path source, so the Q-to-CO carry delay is timed from CLK.
  specify
    (CLK *> Q)   = (1.0, 1.0);
    (CLK => OVF) = (1.0, 1.0);
    (EN => CO)   = (1.0, 1.0);
    (CLK => CO)  = (1.0, 1.0);
    $setuphold(posedge CLK, EN, 1.0, 1.0);
    $setuphold(posedge CLK, LD, 1.0, 1.0);
    $setuphold(posedge CLK, D, 1.0, 1.0);
    $recovery(negedge RST, posedge CLK, 1.0);
  endspecify
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__incr_reg.sv
// Directed and randomized checks of the incrementer register against an
// arithmetic reference model, plus a two-stage cascade.

module tb_gf180mcu_fd_sc_mcu9t5v0__incr_reg;

  logic       CLK;
  logic       RST;
  logic       EN;
  logic       LD;
  logic [3:0] D;
  logic [3:0] Q;
  logic       CO;
  logic       OVF;

  logic       c_ld;
  logic       c_en;
  logic [7:0] c_d;
  logic [3:0] lo_q;
  logic [3:0] hi_q;
  logic       lo_co;
  logic       hi_co;
  logic       lo_ovf;
  logic       hi_ovf;

  int errors = 0;
  int checks = 0;
  int mq     = 0;
  bit movf   = 1'b0;

  gf180mcu_fd_sc_mcu9t5v0__incr_reg #(.WIDTH(4)) dut (
    .CLK (CLK), .RST (RST), .EN (EN), .LD (LD), .D (D),
    .Q (Q), .CO (CO), .OVF (OVF)
  );

  gf180mcu_fd_sc_mcu9t5v0__incr_reg #(.WIDTH(4)) u_lo (
    .CLK (CLK), .RST (RST), .EN (c_en), .LD (c_ld), .D (c_d[3:0]),
    .Q (lo_q), .CO (lo_co), .OVF (lo_ovf)
  );

  gf180mcu_fd_sc_mcu9t5v0__incr_reg #(.WIDTH(4)) u_hi (
    .CLK (CLK), .RST (RST), .EN (lo_co), .LD (c_ld), .D (c_d[7:4]),
    .Q (hi_q), .CO (hi_co), .OVF (hi_ovf)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge: apply inputs, then check CO combinationally.
  task automatic drive(input logic ld, input logic en, input logic [3:0] d);
    LD = ld;
    EN = en;
    D  = d;
    #1;
    chk("co", 16'(CO), (en && mq == 15) ? 16'd1 : 16'd0);
  endtask

  // One clock: update the model from the sampled inputs, check at the falling edge.
  task automatic tick();
    @(posedge CLK);
    if (RST) begin
      mq   = 0;
      movf = 1'b0;
    end else if (LD) begin
      mq   = int'(D);
      movf = 1'b0;
    end else if (EN) begin
      if (mq == 15) movf = 1'b1;
      mq = (mq + 1) % 16;
    end
    @(negedge CLK);
    chk("q", 16'(Q), 16'(mq));
    chk("ovf", 16'(OVF), 16'(movf));
  endtask

  initial begin
    RST = 1'b1; EN = 1'b0; LD = 1'b0; D = 4'h0;
    c_ld = 1'b0; c_en = 1'b0; c_d = 8'h00;
    #1;
    chk("rst_q", 16'(Q), 16'h0);
    chk("rst_ovf", 16'(OVF), 16'h0);
    chk("rst_co", 16'(CO), 16'h0);
    @(negedge CLK);
    RST = 1'b0;

    // Reset mid-cycle after preloading A, and an edge while reset is held.
    drive(1'b1, 1'b0, 4'hA);
    tick();
    drive(1'b0, 1'b1, 4'h0);
    #2;
    RST = 1'b1;
    #1;
    mq = 0; movf = 1'b0;
    chk("midrst_q", 16'(Q), 16'h0);
    chk("midrst_ovf", 16'(OVF), 16'h0);
    chk("midrst_co", 16'(CO), 16'h0);
    tick();
    RST = 1'b0;

    // Count 0..15 and wrap, then three more counts with OVF sticky.
    for (int k = 0; k < 19; k++) begin
      drive(1'b0, 1'b1, 4'h0);
      tick();
    end
    chk("wrap_q", 16'(Q), 16'h3);
    chk("wrap_ovf", 16'(OVF), 16'h1);

    // Load beats increment.
    drive(1'b1, 1'b0, 4'h7);
    tick();
    drive(1'b1, 1'b1, 4'h3);
    tick();
    chk("ldpri_q", 16'(Q), 16'h3);
    chk("ldpri_ovf", 16'(OVF), 16'h0);
    drive(1'b0, 1'b1, 4'h0);
    tick();
    chk("ldpri_next", 16'(Q), 16'h4);

    // Hold at 5 for ten edges.
    drive(1'b1, 1'b0, 4'h5);
    tick();
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b0, 4'hF);
      tick();
    end
    chk("hold_q", 16'(Q), 16'h5);

    // CO follows EN within one cycle while Q sits at 15.
    drive(1'b1, 1'b0, 4'hF);
    tick();
    drive(1'b0, 1'b0, 4'h0);
    drive(1'b0, 1'b1, 4'h0);
    drive(1'b0, 1'b0, 4'h0);
    chk("comb_q", 16'(Q), 16'hF);
    tick();

    // Random traffic with occasional asynchronous resets between edges.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 99) < 3) begin
        RST = 1'b1;
        #1;
        mq = 0; movf = 1'b0;
        chk("rnd_rst_q", 16'(Q), 16'h0);
        chk("rnd_rst_ovf", 16'(OVF), 16'h0);
        RST = 1'b0;
      end
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
            4'($urandom_range(0, 15)));
      tick();
    end
    drive(1'b0, 1'b0, 4'h0);

    // Two-stage cascade from 8'h0E.
    c_d = 8'h0E; c_ld = 1'b1; c_en = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("casc_load", 16'({hi_q, lo_q}), 16'h0E);
    c_ld = 1'b0; c_en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      chk("casc_val", 16'({hi_q, lo_q}), 16'(8'h0E + k));
      chk("casc_hi_ovf", 16'(hi_ovf), 16'h0);
      chk("casc_lo_ovf", 16'(lo_ovf), (k >= 2) ? 16'h1 : 16'h0);
    end
    c_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
